// File: rtl/fsic_axil_cfg_master.sv
// AXI-Lite configuration initiator: turns single-beat register commands into
// AXI-Lite writes (AW+W, no B channel) and reads, with a per-phase timeout.
module fsic_axil_cfg_master #(
    parameter int pADDR_WIDTH = 10,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 16
) (
    input  logic                       axi_clk,
    input  logic                       axi_reset_n,
    // Command / response handshakes: a transfer happens on the rising edge
    // where valid and ready are both high; valid never waits on ready.
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [pADDR_WIDTH+1:2]     cmd_addr,
    input  logic [pDATA_WIDTH-1:0]     cmd_wdata,
    input  logic [pDATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [pDATA_WIDTH-1:0]     rsp_rdata,
    output logic                       rsp_err,
    output logic                       axi_awvalid,
    output logic [pADDR_WIDTH+1:2]     axi_awaddr,
    input  logic                       axi_awready,
    output logic                       axi_wvalid,
    output logic [pDATA_WIDTH-1:0]     axi_wdata,
    output logic [pDATA_WIDTH/8-1:0]   axi_wstrb,
    input  logic                       axi_wready,
    output logic                       axi_arvalid,
    output logic [pADDR_WIDTH+1:2]     axi_araddr,
    input  logic                       axi_arready,
    input  logic                       axi_rvalid,
    input  logic [pDATA_WIDTH-1:0]     axi_rdata,
    output logic                       axi_rready,
    output logic                       busy,
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RA   = 3'd2,
        S_RD   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam int              CW    = $clog2(pTIMEOUT + 1);
    localparam logic [CW-1:0]   TLAST = CW'(pTIMEOUT - 1);
    localparam logic [CW-1:0]   TMAX  = CW'(pTIMEOUT);

    state_t                     r_state;
    state_t                     w_next_state;
    logic                       r_alive;
    logic [CW-1:0]              r_tcnt;
    logic [pADDR_WIDTH+1:2]     r_addr;
    logic [pDATA_WIDTH-1:0]     r_wdata;
    logic [pDATA_WIDTH/8-1:0]   r_wstrb;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic                       r_aw_done;
    logic                       r_w_done;
    logic                       r_arvalid;
    logic                       r_rready;
    logic                       r_rsp_valid;
    logic                       r_rsp_err;
    logic [pDATA_WIDTH-1:0]     r_rsp_rdata;

    logic                       w_cmd_ready;
    logic                       w_cmd_fire;
    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_wr_done;
    logic                       w_timeout;
    logic [CW-1:0]              w_tcnt_inc;

    // r_alive keeps cmd_ready low until the first edge after reset release.
    assign w_cmd_ready = (r_state == S_IDLE) && r_alive;
    assign w_cmd_fire  = cmd_valid && w_cmd_ready;
    assign w_aw_hs     = r_awvalid && axi_awready;
    assign w_w_hs      = r_wvalid && axi_wready;
    assign w_wr_done   = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
    assign w_timeout   = (r_tcnt == TLAST);
    assign w_tcnt_inc  = (r_tcnt == TMAX) ? r_tcnt : r_tcnt + CW'(1);

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_alive <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_cmd_fire) w_next_state = cmd_write ? S_WR : S_RA;
            S_WR:   if (w_wr_done || w_timeout) w_next_state = S_RESP;
            S_RA: begin
                if (axi_arready)    w_next_state = S_RD;
                else if (w_timeout) w_next_state = S_RESP;
            end
            S_RD:   if (axi_rvalid || w_timeout) w_next_state = S_RESP;
            S_RESP: if (rsp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_tcnt      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_addr    <= cmd_addr;
                        r_wdata   <= cmd_wdata;
                        r_wstrb   <= cmd_wstrb;
                        r_tcnt    <= '0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_awvalid <= cmd_write;
                        r_wvalid  <= cmd_write;
                        r_arvalid <= !cmd_write;
                    end
                end
                S_WR: begin
                    r_tcnt <= w_tcnt_inc;
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    // A handshake landing on the last counted cycle still completes.
                    if (w_wr_done || w_timeout) begin
                        r_awvalid   <= 1'b0;
                        r_wvalid    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !w_wr_done;
                        r_rsp_rdata <= '0;
                    end
                end
                S_RA: begin
                    if (axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_tcnt    <= '0;
                    end else if (w_timeout) begin
                        r_arvalid   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_tcnt <= w_tcnt_inc;
                    end
                end
                S_RD: begin
                    r_tcnt <= w_tcnt_inc;
                    if (axi_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= axi_rdata;
                    end else if (w_timeout) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: begin
                    r_awvalid   <= 1'b0;
                    r_wvalid    <= 1'b0;
                    r_arvalid   <= 1'b0;
                    r_rready    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign busy        = (r_state != S_IDLE);
    assign dbg_state   = r_state;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_rdata   = r_rsp_rdata;
    assign axi_awvalid = r_awvalid;
    assign axi_awaddr  = r_addr;
    assign axi_wvalid  = r_wvalid;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = r_wstrb;
    assign axi_arvalid = r_arvalid;
    assign axi_araddr  = r_addr;
    assign axi_rready  = r_rready;

endmodule

// File: tb/tb_fsic_axil_cfg_master.sv
// Directed bench for fsic_axil_cfg_master: latency-programmable AXI-Lite
// responder, response scoreboard and per-cycle protocol checks.
module tb_fsic_axil_cfg_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW+1:2] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          axi_awvalid, axi_awready = 1'b0;
  logic [AW+1:2] axi_awaddr, axi_araddr;
  logic          axi_wvalid, axi_wready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [3:0]    axi_wstrb;
  logic          axi_arvalid, axi_arready = 1'b0;
  logic          axi_rvalid = 1'b0;
  logic [DW-1:0] axi_rdata = '0;
  logic          axi_rready;
  logic          busy;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  fsic_axil_cfg_master #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTIMEOUT(TO)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_awvalid(axi_awvalid), .axi_awaddr(axi_awaddr), .axi_awready(axi_awready),
    .axi_wvalid(axi_wvalid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_arvalid(axi_arvalid), .axi_araddr(axi_araddr), .axi_arready(axi_arready),
    .axi_rvalid(axi_rvalid), .axi_rdata(axi_rdata), .axi_rready(axi_rready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- responder model ----------------
  // A latency of N raises ready after the valid has waited N cycles; -1 = never.
  int            aw_lat = 0, w_lat = 0, ar_lat = 0, r_lat = 0;
  int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int            aw_hs_n = 0, w_hs_n = 0, rr_high_n = 0;
  logic          have_aw = 1'b0, have_w = 1'b0;
  logic [AW+1:2] pend_aw = '0, raddr = '0;
  logic [DW-1:0] pend_wdata = '0;
  logic [3:0]    pend_wstrb = '0;
  logic [DW-1:0] mem [0:7] = '{default: '0};

  always @(posedge clk) begin
    if (axi_awvalid && axi_awready) begin
      aw_hs_n++; pend_aw = axi_awaddr; have_aw = 1'b1; aw_cnt = 0;
    end else if (axi_awvalid) aw_cnt++;
    else aw_cnt = 0;
    if (axi_wvalid && axi_wready) begin
      w_hs_n++; pend_wdata = axi_wdata; pend_wstrb = axi_wstrb; have_w = 1'b1; w_cnt = 0;
    end else if (axi_wvalid) w_cnt++;
    else w_cnt = 0;
    if (have_aw && have_w) begin
      for (int b = 0; b < 4; b++)
        if (pend_wstrb[b]) mem[pend_aw[4:2]][8*b +: 8] = pend_wdata[8*b +: 8];
      have_aw = 1'b0; have_w = 1'b0;
    end
    if (axi_arvalid && axi_arready) begin
      raddr = axi_araddr; ar_cnt = 0;
    end else if (axi_arvalid) ar_cnt++;
    else ar_cnt = 0;
    if (axi_rvalid && axi_rready) r_cnt = 0;
    else if (axi_rready) r_cnt++;
    else r_cnt = 0;
  end

  always @(negedge clk) begin
    axi_awready = (aw_lat >= 0) && (aw_cnt >= aw_lat);
    axi_wready  = (w_lat >= 0) && (w_cnt >= w_lat);
    axi_arready = (ar_lat >= 0) && (ar_cnt >= ar_lat);
    axi_rvalid  = (r_lat >= 0) && (r_cnt >= r_lat);
    axi_rdata   = mem[raddr[4:2]];
    if (axi_rready) rr_high_n++;
  end

  // ---------------- scoreboard / checking ----------------
  logic [DW:0] exp_q[$];
  int n_pass = 0, n_fail = 0, n_total = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {cmd_ready, rsp_valid, rsp_err, axi_awvalid, axi_wvalid,
                           axi_arvalid, axi_rready, busy, dbg_state}, '0);
    check({tag, "_data"}, {rsp_rdata, axi_wdata, axi_wstrb, axi_awaddr, axi_araddr}, '0);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of cycle T0+1 (T0 = acceptance edge).
  task automatic issue(input logic wr, input logic [AW+1:2] addr,
                       input logic [DW-1:0] data, input logic [3:0] strb);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits for a response, scores it, pops it with a one-cycle rsp_ready pulse.
  task automatic get_rsp(input string tag);
    int n;
    logic [DW:0] exp;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b1, {DW{1'b1}}};
    check({tag, "_rsp"}, {rsp_err, rsp_rdata}, exp);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_aw, b_w, b_r;
    logic [2:0] skew_exp [1:5];
    skew_exp[1] = 3'b110; skew_exp[2] = 3'b010; skew_exp[3] = 3'b010;
    skew_exp[4] = 3'b010; skew_exp[5] = 3'b001;

    // reset: outputs zero, cmd_ready only after first edge post-release
    step(1);
    check_all_zero("reset");
    #2 rst_n = 1'b1;
    #1 check("cmd_ready_pre_edge", cmd_ready, 1'b0);
    step(1);
    check("cmd_ready_post_edge", {cmd_ready, busy}, 2'b10);

    // write 3 to address 0, always-ready responder
    b_aw = aw_hs_n; b_w = w_hs_n;
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 10'h000, 32'h0000_0003, 4'hF);
    check("wr_t1_valids", {axi_awvalid, axi_wvalid, rsp_valid, busy}, 4'b1101);
    check("wr_t1_payload", {axi_awaddr, axi_wdata, axi_wstrb}, {10'h000, 32'h3, 4'hF});
    step(1);
    check("wr_t2_state", {axi_awvalid, axi_wvalid, rsp_valid}, 3'b001);
    check("wr_hs_count", {aw_hs_n - b_aw, w_hs_n - b_w}, {32'd1, 32'd1});
    check("wr_mem0", mem[0], 32'h3);
    get_rsp("wr");
    check("wr_cmd_ready_after", cmd_ready, 1'b1);

    // read address 0 back
    b_r = rr_high_n;
    exp_q.push_back({1'b0, 32'h3});
    issue(1'b0, 10'h000, 32'h0, 4'h0);
    check("rd_t1", {axi_arvalid, axi_araddr, axi_rready}, {1'b1, 10'h000, 1'b0});
    step(1);
    check("rd_t2", {axi_arvalid, axi_rready, rsp_valid}, 3'b010);
    step(1);
    check("rd_t3", {rsp_valid, axi_rready, rsp_rdata}, {1'b1, 1'b0, 32'h3});
    check("rd_rready_cycles", rr_high_n - b_r, 1);
    get_rsp("rd");

    // skewed write: awready at cycle 1, wready at cycle 4
    aw_lat = 0; w_lat = 3;
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 10'h001, 32'h0000_0002, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("skew_t%0d", k), {axi_awvalid, axi_wvalid, rsp_valid}, skew_exp[k]);
      if (k < 5) step(1);
    end
    check("skew_mem1", mem[1], 32'h2);
    get_rsp("skew");

    // W handshake on the last counted cycle: completion beats timeout
    aw_lat = 0; w_lat = TO - 1;
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 10'h002, 32'h1234_565A, 4'h1);
    step(TO - 1);
    check("late_w_t16", {axi_wvalid, rsp_valid}, 2'b10);
    step(1);
    check("late_w_t17", {rsp_valid, rsp_err, axi_wvalid}, 3'b100);
    get_rsp("late_w");
    check("late_w_mem2", mem[2], 32'h0000_005A);

    // write timeout, responder never ready
    aw_lat = -1; w_lat = -1; ar_lat = -1; r_lat = -1;
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b1, 10'h003, 32'hFFFF_FFFF, 4'hF);
    step(TO - 1);
    check("to_t16", {rsp_valid, axi_awvalid, axi_wvalid, busy}, 4'b0111);
    step(1);
    check("to_t17", {rsp_valid, rsp_err, rsp_rdata, axi_awvalid, axi_wvalid, axi_arvalid, axi_rready},
          {1'b1, 1'b1, 32'h0, 4'b0000});
    get_rsp("to_wr");
    check("to_mem3", mem[3], 32'h0);

    // read timeout in RD (address phase accepted, no data)
    ar_lat = 0;
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 10'h000, 32'h0, 4'h0);
    get_rsp("to_rd");
    check("to_rd_rready_low", {axi_rready, axi_arvalid}, 2'b00);

    // next command after timeout completes normally
    aw_lat = 0; w_lat = 0; ar_lat = 0; r_lat = 0;
    exp_q.push_back({1'b0, 32'h3});
    issue(1'b0, 10'h000, 32'h0, 4'h0);
    get_rsp("after_to");

    // response backpressure for 10 cycles
    exp_q.push_back({1'b0, 32'h2});
    issue(1'b0, 10'h001, 32'h0, 4'h0);
    step(2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold_%0d", k), {rsp_valid, rsp_err, rsp_rdata, cmd_ready}, {1'b1, 1'b0, 32'h2, 1'b0});
      step(1);
    end
    get_rsp("hold");
    check("hold_cmd_ready_after", cmd_ready, 1'b1);

    // reset asserted while in RD
    r_lat = -1;
    exp_q.push_back({1'b0, 32'h3});
    issue(1'b0, 10'h000, 32'h0, 4'h0);
    step(1);
    check("rst_rd_in_rd", {axi_rready, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    exp_q.delete();
    step(2);
    check_all_zero("rst_held");
    #2 rst_n = 1'b1;
    #1 check("rst_cmd_ready_pre_edge", cmd_ready, 1'b0);
    step(1);
    check("rst_cmd_ready_post_edge", cmd_ready, 1'b1);
    r_lat = 0;
    exp_q.push_back({1'b0, 32'h3});
    issue(1'b0, 10'h000, 32'h0, 4'h0);
    get_rsp("rst_recover");

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
